tm1638_key_reader: RTL and testbench

- Reads the key-scan matrix of the TM1638 display/keypad board. This is the read direction of the same 3-wire clk/stb/dio bus that the display writer drives.
- Periodically issues read-key command 0x42, turns DIO around and clocks in 4 key bytes. Decodes the 8 board buttons into `keys`, with pressed-edge pulses.
- Shares the bus with the display writer through a req/gnt handshake. The top level muxes the pins and builds the DIO tristate from dio_out/dio_oe.

---
 rtl/tm1638_key_reader_if.sv | 31 +++
 rtl/tm1638_key_reader.sv | 207 ++++++++++++++++++++
 tb/tb_tm1638_key_reader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/tm1638_key_reader_if.sv
// TM1638 pin bundle plus bus arbitration handshake.
// master: key reader drives req and pins; slave: arbiter / board side.
interface tm1638_key_reader_if;
  logic bus_req;
  logic bus_gnt;
  logic tm_clk;
  logic tm_stb;
  logic dio_out;
  logic dio_oe;
  logic dio_in;

  modport master (
    output bus_req,
    output tm_clk,
    output tm_stb,
    output dio_out,
    output dio_oe,
    input  bus_gnt,
    input  dio_in
  );

  modport slave (
    input  bus_req,
    input  tm_clk,
    input  tm_stb,
    input  dio_out,
    input  dio_oe,
    output bus_gnt,
    output dio_in
  );
endinterface

// File: rtl/tm1638_key_reader.sv
// TM1638 key scanner: periodically sends 0x42, reads 4 key bytes, decodes 8 keys.
// Ports: clk_50M/rst_n/scan_en, bus (req/gnt + pins), key_raw/keys/key_press/key_valid/busy.
module tm1638_key_reader #(
  parameter int CLK_DIV     = 25,
  parameter int WAIT_CYCLES = 50,
  parameter int SCAN_PERIOD = 500000
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        scan_en,
  tm1638_key_reader_if.master bus,
  output logic [31:0] key_raw,
  output logic [7:0]  keys,
  output logic [7:0]  key_press,
  output logic        key_valid,
  output logic        busy
);

  localparam int CW = $clog2(CLK_DIV + WAIT_CYCLES + 1);
  localparam int PW = $clog2(SCAN_PERIOD + 1);
  localparam logic [CW-1:0] DIV_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] WAIT_END = CW'(WAIT_CYCLES - 1);
  localparam logic [PW-1:0] PER_END  = PW'(SCAN_PERIOD - 1);
  localparam logic [7:0]    CMD_BYTE = 8'h42;

  typedef enum logic [2:0] {
    IDLE, REQ, STB_LO, CMD, TWAIT, READ, STB_HI, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ph_q, ph_d;
  logic [4:0]    bit_q, bit_d;
  logic          abort_q, abort_d;
  logic [PW-1:0] per_q;
  logic [1:0]    sync_q;
  logic [31:0]   sr_q;

  logic clk_d, stb_d, dout_d, oe_d, req_d;
  logic [7:0] new_keys;
  logic div_end, wrap, on_bus;

  assign div_end = (cnt_q == DIV_END);
  assign wrap    = scan_en && (per_q == PER_END);
  assign on_bus  = (state_q == STB_LO) || (state_q == CMD) ||
                   (state_q == TWAIT)  || (state_q == READ);

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ph_q        <= 1'b0;
      bit_q       <= '0;
      abort_q     <= 1'b0;
      per_q       <= '0;
      sync_q      <= 2'b00;
      sr_q        <= '0;
      bus.tm_clk  <= 1'b1;
      bus.tm_stb  <= 1'b1;
      bus.dio_out <= 1'b1;
      bus.dio_oe  <= 1'b0;
      bus.bus_req <= 1'b0;
      busy        <= 1'b0;
      key_raw     <= '0;
      keys        <= '0;
      key_press   <= '0;
      key_valid   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ph_q        <= ph_d;
      bit_q       <= bit_d;
      abort_q     <= abort_d;
      sync_q      <= {sync_q[0], bus.dio_in};
      if (!scan_en || per_q == PER_END)
        per_q <= '0;
      else
        per_q <= per_q + PW'(1);
      // Sample on the last low-phase cycle, just before tm_clk rises.
      if (state_q == READ && !ph_q && div_end)
        sr_q[bit_q] <= sync_q[1];
      bus.tm_clk  <= clk_d;
      bus.tm_stb  <= stb_d;
      bus.dio_out <= dout_d;
      bus.dio_oe  <= oe_d;
      bus.bus_req <= req_d;
      busy        <= req_d;
      key_valid   <= 1'b0;
      key_press   <= '0;
      if (state_d == DONE) begin
        key_raw   <= sr_q;
        keys      <= new_keys;
        key_press <= new_keys & ~keys;
        key_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    ph_d    = ph_q;
    bit_d   = bit_q;
    abort_d = abort_q;
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        if (wrap) state_d = REQ;
      end
      REQ: begin
        cnt_d = '0;
        if (bus.bus_gnt) state_d = STB_LO;
      end
      STB_LO: begin
        if (div_end) begin
          state_d = CMD;
          cnt_d   = '0;
          ph_d    = 1'b0;
          bit_d   = '0;
        end
      end
      CMD, READ: begin
        if (div_end) begin
          cnt_d = '0;
          ph_d  = ~ph_q;
          if (ph_q) begin
            bit_d = bit_q + 5'd1;
            if (state_q == CMD && bit_q == 5'd7)
              state_d = TWAIT;
            if (state_q == READ && bit_q == 5'd31)
              state_d = STB_HI;
          end
        end
      end
      TWAIT: begin
        if (cnt_q == WAIT_END) begin
          state_d = READ;
          cnt_d   = '0;
          ph_d    = 1'b0;
          bit_d   = '0;
        end
      end
      STB_HI: begin
        if (div_end) begin
          state_d = abort_q ? IDLE : DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    // Losing the grant while owning the pins releases them at once.
    if (on_bus && !bus.bus_gnt) begin
      state_d = STB_HI;
      cnt_d   = '0;
      abort_d = 1'b1;
    end
  end

  // Pin values are decoded from the next state so they track it exactly.
  always_comb begin
    clk_d  = 1'b1;
    stb_d  = 1'b1;
    dout_d = 1'b1;
    oe_d   = 1'b0;
    req_d  = 1'b0;
    unique case (state_d)
      REQ: req_d = 1'b1;
      STB_LO: begin
        req_d = 1'b1;
        stb_d = 1'b0;
        oe_d  = 1'b1;
      end
      CMD: begin
        req_d  = 1'b1;
        stb_d  = 1'b0;
        oe_d   = 1'b1;
        clk_d  = ph_d;
        dout_d = CMD_BYTE[bit_d[2:0]];
      end
      TWAIT: begin
        req_d = 1'b1;
        stb_d = 1'b0;
      end
      READ: begin
        req_d = 1'b1;
        stb_d = 1'b0;
        clk_d = ph_d;
      end
      STB_HI: req_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    new_keys = '0;
    for (int i = 0; i < 4; i++) begin
      new_keys[i]   = sr_q[8*i];
      new_keys[i+4] = sr_q[8*i+4];
    end
  end

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Directed bench for tm1638_key_reader with a behavioural TM1638 DIO model.
// Small timing parameters keep each scan a few hundred cycles.
module tb_tm1638_key_reader;

  localparam int CD = 4;
  localparam int WC = 8;
  localparam int SP = 400;

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic        scan_en;
  logic [31:0] key_raw;
  logic [7:0]  keys;
  logic [7:0]  key_press;
  logic        key_valid;
  logic        busy;

  tm1638_key_reader_if bus();

  tm1638_key_reader #(
    .CLK_DIV(CD),
    .WAIT_CYCLES(WC),
    .SCAN_PERIOD(SP)
  ) dut (
    .clk_50M(clk_50M),
    .rst_n(rst_n),
    .scan_en(scan_en),
    .bus(bus),
    .key_raw(key_raw),
    .keys(keys),
    .key_press(key_press),
    .key_valid(key_valid),
    .busy(busy)
  );

  always #10 clk_50M = ~clk_50M;

  int total = 0;
  int bad = 0;

  logic [31:0] rd_data;
  logic        rd_bit = 1'b1;
  int          fcnt = 0;
  int          rcnt = 0;
  logic [7:0]  cmd_seen = '0;
  int          oe_fall_at = -1;
  logic        oe_fall_clk = 1'b0;
  int          tog = 0;
  int          vcnt = 0;

  assign bus.dio_in = bus.dio_oe ? bus.dio_out : rd_bit;

  always @(negedge bus.tm_stb) begin
    fcnt = 0;
    rcnt = 0;
  end

  // TM1638 shifts a key bit out after each falling edge once the
  // 8 command clocks are done.
  always @(negedge bus.tm_clk) begin
    if (!bus.tm_stb) begin
      fcnt = fcnt + 1;
      if (fcnt >= 9 && fcnt <= 40)
        rd_bit = rd_data[fcnt-9];
    end
  end

  always @(posedge bus.tm_clk) begin
    if (!bus.tm_stb) begin
      if (rcnt < 8) cmd_seen[rcnt] = bus.dio_out;
      rcnt = rcnt + 1;
    end
  end

  always @(negedge bus.dio_oe) begin
    if (!bus.tm_stb) begin
      oe_fall_at  = rcnt;
      oe_fall_clk = bus.tm_clk;
    end
  end

  always @(bus.tm_clk) tog = tog + 1;

  always @(negedge clk_50M) if (key_valid) vcnt = vcnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk_50M);
      n++;
    end while (!key_valid && n < budget);
    chk(tag, {31'd0, key_valid}, 32'd1);
  endtask

  task automatic wait_stb_low(input string tag, input int budget);
    int n = 0;
    while (bus.tm_stb && n < budget) begin
      @(negedge clk_50M);
      n++;
    end
    chk(tag, {31'd0, bus.tm_stb}, 32'd0);
  endtask

  initial begin
    int n;
    int tog0;
    int vcnt0;
    rst_n = 1'b0;
    scan_en = 1'b0;
    bus.bus_gnt = 1'b1;
    rd_data = 32'h1100_1001;
    repeat (3) @(negedge clk_50M);

    chk("rst_clk", {31'd0, bus.tm_clk}, 32'd1);
    chk("rst_stb", {31'd0, bus.tm_stb}, 32'd1);
    chk("rst_dout", {31'd0, bus.dio_out}, 32'd1);
    chk("rst_oe", {31'd0, bus.dio_oe}, 32'd0);
    chk("rst_req", {31'd0, bus.bus_req}, 32'd0);
    chk("rst_raw", key_raw, 32'd0);
    chk("rst_keys", {24'd0, keys}, 32'd0);
    chk("rst_press", {24'd0, key_press}, 32'd0);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // First scan: bytes 01,10,00,11
    rst_n = 1'b1;
    scan_en = 1'b1;
    wait_valid("scan1_valid", 1000);
    chk("scan1_raw", key_raw, 32'h1100_1001);
    chk("scan1_keys", {24'd0, keys}, 32'h0000_00A9);
    chk("scan1_press", {24'd0, key_press}, 32'h0000_00A9);
    chk("scan1_cmd", {24'd0, cmd_seen}, 32'h0000_0042);
    chk("scan1_edges", rcnt, 32'd40);
    chk("scan1_oe_at", oe_fall_at, 32'd8);
    chk("scan1_oe_clk", {31'd0, oe_fall_clk}, 32'd1);
    @(negedge clk_50M);
    chk("scan1_vpulse", {31'd0, key_valid}, 32'd0);
    chk("scan1_ppulse", {24'd0, key_press}, 32'd0);

    // Same bytes again: no new presses
    wait_valid("scan2_valid", 1000);
    chk("scan2_keys", {24'd0, keys}, 32'h0000_00A9);
    chk("scan2_press", {24'd0, key_press}, 32'd0);

    // New pattern: bytes 11,01,10,00
    rd_data = 32'h0010_0111;
    wait_valid("scan3_valid", 1000);
    chk("scan3_raw", key_raw, 32'h0010_0111);
    chk("scan3_keys", {24'd0, keys}, 32'h0000_0053);
    chk("scan3_press", {24'd0, key_press}, 32'h0000_0052);

    // Grant withheld: request pends, pins stay idle
    @(negedge clk_50M);
    bus.bus_gnt = 1'b0;
    n = 0;
    while (!bus.bus_req && n < 600) begin
      @(negedge clk_50M);
      n++;
    end
    chk("hold_req", {31'd0, bus.bus_req}, 32'd1);
    tog0 = tog;
    repeat (1000) @(negedge clk_50M);
    chk("hold_req2", {31'd0, bus.bus_req}, 32'd1);
    chk("hold_stb", {31'd0, bus.tm_stb}, 32'd1);
    chk("hold_tog", tog - tog0, 32'd0);
    bus.bus_gnt = 1'b1;
    wait_valid("hold_valid", 1000);
    chk("hold_keys", {24'd0, keys}, 32'h0000_0053);

    // Grant lost during READ bit 10
    rd_data = 32'hFFFF_FFFF;
    wait_stb_low("drop_start", 1000);
    n = 0;
    while (!(rcnt == 18 && !bus.tm_clk) && n < 500) begin
      @(negedge clk_50M);
      n++;
    end
    chk("drop_bit10", rcnt, 32'd18);
    vcnt0 = vcnt;
    bus.bus_gnt = 1'b0;
    n = 0;
    while (!bus.tm_stb && n < CD + 1) begin
      @(negedge clk_50M);
      n++;
    end
    chk("drop_stb", {31'd0, bus.tm_stb}, 32'd1);
    repeat (20) @(negedge clk_50M);
    chk("drop_busy", {31'd0, busy}, 32'd0);
    chk("drop_keys", {24'd0, keys}, 32'h0000_0053);
    chk("drop_novalid", vcnt - vcnt0, 32'd0);
    bus.bus_gnt = 1'b1;

    // Reset during the command byte
    wait_stb_low("rstcmd_start", 1000);
    n = 0;
    while (rcnt < 3 && n < 200) begin
      @(negedge clk_50M);
      n++;
    end
    chk("rstcmd_incmd", {31'd0, bus.dio_oe}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk_50M);
    chk("rstcmd_stb", {31'd0, bus.tm_stb}, 32'd1);
    chk("rstcmd_clk", {31'd0, bus.tm_clk}, 32'd1);
    chk("rstcmd_oe", {31'd0, bus.dio_oe}, 32'd0);
    chk("rstcmd_keys", {24'd0, keys}, 32'd0);
    chk("rstcmd_busy", {31'd0, busy}, 32'd0);
    chk("rstcmd_req", {31'd0, bus.bus_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
